// File: rtl/ram_writer_pkg.sv
// rtl/ram_writer_pkg.sv - shared widths, depth and FSM state encoding for ram_writer
package ram_writer_pkg;

    localparam int AW_DEF = 4;
    localparam int DW_DEF = 8;
    localparam int DEPTH  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/ram_writer_if.sv
// rtl/ram_writer_if.sv - byte-stream input and RAM port bundle for ram_writer
interface ram_writer_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // writer side: consumes the stream, drives the RAM pins
    modport master (
        input  in_valid, in_data, mem_rdata,
        output in_ready, mem_addr, mem_wr_en, mem_wdata
    );

    // source / RAM side
    modport slave (
        output in_valid, in_data, mem_rdata,
        input  in_ready, mem_addr, mem_wr_en, mem_wdata
    );
endinterface

// File: rtl/ram_writer_xor_accum.sv
// rtl/ram_writer_xor_accum.sv - DW-bit XOR accumulator with synchronous clear and enable
module ram_writer_xor_accum #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] acc
);

    logic [DW-1:0] acc_q;
    logic [DW-1:0] acc_d;

    // clear wins over accumulate so a new job starts from zero
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q ^ din;
        end
    end

    // accumulator register, active-low asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/ram_writer.sv
// rtl/ram_writer.sv - streams bytes into consecutive RAM addresses with optional checksum readback
module ram_writer
    import ram_writer_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   count,
    input  logic          verify_en,
    ram_writer_if.master  bus,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] chk
);

    state_t        state_q,    state_d;
    logic [AW-1:0] addr_q,     addr_d;
    logic [AW-1:0] base_q,     base_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [AW:0]   count_q,    count_d;
    logic [AW:0]   rem_q,      rem_d;
    logic          verify_q,   verify_d;
    logic          wr_en_q,    wr_en_d;
    logic          err_q,      err_d;
    logic [DW-1:0] wdata_q,    wdata_d;

    logic [DW-1:0] rd_chk;
    logic          chk_clr, chk_en;
    logic          rd_clr,  rd_en;

    // Next-state logic. WRITE with rem_q == 0 is a one-cycle drain that
    // overlaps the final write strobe, so the last byte has landed in the
    // RAM before VERIFY reads it and done follows the last strobe by one cycle.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        base_d     = base_q;
        mem_addr_d = mem_addr_q;
        count_d    = count_q;
        rem_d      = rem_q;
        verify_d   = verify_q;
        wr_en_d    = 1'b0;
        err_d      = err_q;
        wdata_d    = wdata_q;
        chk_clr    = 1'b0;
        chk_en     = 1'b0;
        rd_clr     = 1'b0;
        rd_en      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    base_d   = base_addr;
                    count_d  = count;
                    rem_d    = count;
                    verify_d = verify_en;
                    err_d    = 1'b0;
                    chk_clr  = 1'b1;
                    rd_clr   = 1'b1;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                if (rem_q != '0) begin
                    if (bus.in_valid) begin
                        wdata_d    = bus.in_data;
                        mem_addr_d = addr_q;
                        wr_en_d    = 1'b1;
                        chk_en     = 1'b1;
                        addr_d     = addr_q + 1'b1;
                        rem_d      = rem_q - 1'b1;
                    end
                end else if (verify_q && (count_q != '0)) begin
                    mem_addr_d = base_q;
                    rem_d      = count_q;
                    state_d    = VERIFY;
                end else begin
                    state_d = DONE;
                end
            end
            VERIFY: begin
                rd_en      = 1'b1;
                mem_addr_d = mem_addr_q + 1'b1;
                rem_d      = rem_q - 1'b1;
                if (rem_q == (AW+1)'(1)) begin
                    // fold in the final read directly rather than waiting a cycle
                    err_d   = ((rd_chk ^ bus.mem_rdata) != chk);
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state and datapath registers, active-low asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            base_q     <= '0;
            mem_addr_q <= '0;
            count_q    <= '0;
            rem_q      <= '0;
            verify_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            err_q      <= 1'b0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            base_q     <= base_d;
            mem_addr_q <= mem_addr_d;
            count_q    <= count_d;
            rem_q      <= rem_d;
            verify_q   <= verify_d;
            wr_en_q    <= wr_en_d;
            err_q      <= err_d;
            wdata_q    <= wdata_d;
        end
    end

    ram_writer_xor_accum #(.DW(DW)) u_chk (
        .clk (clk),
        .rst (rst),
        .clr (chk_clr),
        .en  (chk_en),
        .din (bus.in_data),
        .acc (chk)
    );

    ram_writer_xor_accum #(.DW(DW)) u_rd_chk (
        .clk (clk),
        .rst (rst),
        .clr (rd_clr),
        .en  (rd_en),
        .din (bus.mem_rdata),
        .acc (rd_chk)
    );

    assign bus.in_ready  = (state_q == WRITE) && (rem_q != '0);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wr_en = wr_en_q;
    assign bus.mem_wdata = wdata_q;
    assign busy          = (state_q == WRITE) || (state_q == VERIFY);
    assign done          = (state_q == DONE);
    assign err           = err_q;

endmodule
